// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences one instruction at a time
// through fetch/decode/execute/memory/writeback and decodes datapath controls from state.
module multicycle_main_fsm #(
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       MemReady,
   output logic       PCUpdate,
   output logic       Branch,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] DecOp,
   output logic       IllegalInstr,
   output logic       InstrDone,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BRANCH   = 4'd10,
      S_JALR     = 4'd11,
      S_JALRWB   = 4'd12,
      S_LUI      = 4'd13
   } state_t;

   state_t r_state;
   state_t w_decState;
   logic   w_ready;
   logic   w_legal;

   // With the handshake disabled MemReady may be X, so it must never reach the logic.
   assign w_ready = MEM_HANDSHAKE ? MemReady : 1'b1;
   assign State   = r_state;

   always_comb begin
      case (op)
         7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: w_legal = 1'b1;
         default:                                         w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:    r_state <= w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
               case (op)
                  7'b0000011, 7'b0100011: r_state <= S_MEMADR;
                  7'b0110011:             r_state <= S_EXECR;
                  7'b0010011:             r_state <= S_EXECI;
                  7'b1100011:             r_state <= S_BRANCH;
                  7'b1101111:             r_state <= S_JAL;
                  7'b1100111:             r_state <= S_JALR;
                  7'b0110111:             r_state <= S_LUI;
                  7'b0010111:             r_state <= S_ALUWB;
                  default:                r_state <= S_FETCH;
               endcase
            end
            S_MEMADR:   r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  r_state <= w_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: r_state <= w_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_LUI, S_JAL: r_state <= S_ALUWB;
            S_JALR:     r_state <= S_JALRWB;
            default:    r_state <= S_FETCH;
         endcase
      end
   end

   // Reset shows FETCH selects; strobes are cleared afterwards so nothing writes mid-reset.
   always_comb begin
      w_decState   = reset ? S_FETCH : r_state;
      PCUpdate     = 1'b0;
      Branch       = 1'b0;
      RegWrite     = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      AdrSrc       = 1'b0;
      ResultSrc    = 2'b00;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      DecOp        = 2'b00;
      IllegalInstr = 1'b0;
      InstrDone    = 1'b0;
      case (w_decState)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            DecOp     = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = w_ready;
            PCUpdate  = w_ready;
         end
         S_DECODE: begin
            ALUSrcA      = 2'b01;
            ALUSrcB      = 2'b01;
            DecOp        = 2'b10;
            IllegalInstr = ~w_legal;
            InstrDone    = ~w_legal;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            MemWrite  = 1'b1;
            InstrDone = w_ready;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            DecOp   = 2'b11;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            DecOp   = 2'b11;
         end
         S_LUI: begin
            ALUSrcA = 2'b11;
            ALUSrcB = 2'b01;
            DecOp   = 2'b10;
         end
         S_ALUWB: begin
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         S_JAL: begin
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            DecOp    = 2'b10;
            PCUpdate = 1'b1;
         end
         S_JALR: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            DecOp     = 2'b10;
            ResultSrc = 2'b10;
            PCUpdate  = 1'b1;
         end
         S_JALRWB: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            DecOp     = 2'b10;
            ResultSrc = 2'b10;
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA   = 2'b10;
            DecOp     = 2'b01;
            Branch    = 1'b1;
            InstrDone = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         PCUpdate     = 1'b0;
         Branch       = 1'b0;
         RegWrite     = 1'b0;
         MemWrite     = 1'b0;
         IRWrite      = 1'b0;
         IllegalInstr = 1'b0;
         InstrDone    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Randomised instruction stream for the main control FSM, checked against per-opcode
// state paths, a control table and per-instruction cycle counts held in the bench.
module tb_multicycle_main_fsm;

   logic       clock;
   logic       reset;
   logic [6:0] op;
   logic       MemReady;
   logic       PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, DecOp;
   logic       IllegalInstr, InstrDone;
   logic [3:0] State;
   logic [15:0] obsVec;

   int errors = 0;
   int checks = 0;

   multicycle_main_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
      .clk(clock), .reset(reset), .op(op), .MemReady(MemReady),
      .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .DecOp(DecOp), .IllegalInstr(IllegalInstr),
      .InstrDone(InstrDone), .State(State)
   );

   assign obsVec = {PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, ResultSrc,
                    ALUSrcA, ALUSrcB, DecOp, IllegalInstr, InstrDone};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   localparam logic [6:0] OPS [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                     7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                     7'b0010111};
   // Cycles from FETCH entry to the InstrDone cycle with no memory waits; index 9 = illegal.
   localparam int BASE_CYC [10] = '{5, 4, 4, 4, 3, 4, 4, 4, 3, 2};
   localparam logic [15:0] RESET_VEC = {6'b0, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00};

   function automatic bit isLegal(logic [6:0] o);
      for (int k = 0; k < 9; k++) if (OPS[k] == o) return 1'b1;
      return 1'b0;
   endfunction

   // Control table: {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,ResultSrc,A,B,DecOp,Ill,Done}
   function automatic logic [15:0] expOut(int st, logic [6:0] o, logic rdy);
      logic ill;
      ill = ~isLegal(o);
      case (st)
         0:  return {rdy, 1'b0, 1'b0, 1'b0, rdy, 1'b0, 2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0};
         1:  return {5'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, ill, ill};
         2:  return {6'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
         3:  return {5'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
         4:  return {2'b0, 1'b1, 3'b0, 2'b01, 6'b0, 1'b0, 1'b1};
         5:  return {3'b0, 1'b1, 1'b0, 1'b1, 2'b00, 6'b0, 1'b0, rdy};
         6:  return {6'b0, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00};
         7:  return {6'b0, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
         8:  return {2'b0, 1'b1, 3'b0, 2'b00, 6'b0, 1'b0, 1'b1};
         9:  return {1'b1, 5'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
         10: return {1'b0, 1'b1, 4'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b1};
         11: return {1'b1, 5'b0, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00};
         12: return {2'b0, 1'b1, 3'b0, 2'b10, 2'b01, 2'b10, 2'b10, 1'b0, 1'b1};
         13: return {6'b0, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00};
         default: return 16'hxxxx;
      endcase
   endfunction

   task automatic applyStimulus(input logic r, input logic [6:0] o, input logic rdy);
      reset    = r;
      op       = o;
      MemReady = rdy;
   endtask

   task automatic checkOutput(input string tag, input int expState, input logic [15:0] expVec);
      checks++;
      assert (State === 4'(expState)) else begin
         errors++;
         $error("[TB] FAIL %s state observed=%0d expected=%0d", tag, State, expState);
      end
      checks++;
      assert (obsVec === expVec) else begin
         errors++;
         $error("[TB] FAIL %s controls observed=%b expected=%b", tag, obsVec, expVec);
      end
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int kind, waits, cyc, doneAt, st, nWait;
      int path[$];
      logic [6:0] o;
      logic rdy;

      applyStimulus(1'b1, 7'b0110011, 1'b1);
      @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         checkOutput("reset", 0, RESET_VEC);
         nextCycle();
      end
      reset = 1'b0;

      for (int n = 0; n < 80; n++) begin
         kind = (n < 10) ? n : int'($urandom_range(0, 9));
         if (kind < 9) o = OPS[kind];
         else begin
            o = 7'($urandom_range(0, 127));
            while (isLegal(o)) o = 7'($urandom_range(0, 127));
         end
         case (kind)
            0: path = '{0, 1, 2, 3, 4};
            1: path = '{0, 1, 2, 5};
            2: path = '{0, 1, 6, 8};
            3: path = '{0, 1, 7, 8};
            4: path = '{0, 1, 10};
            5: path = '{0, 1, 9, 8};
            6: path = '{0, 1, 11, 12};
            7: path = '{0, 1, 13, 8};
            8: path = '{0, 1, 8};
            default: path = '{0, 1};
         endcase
         waits  = 0;
         cyc    = 0;
         doneAt = -1;
         foreach (path[i]) begin
            st    = path[i];
            nWait = 0;
            do begin
               if (st == 0 || st == 3 || st == 5)
                  rdy = (nWait >= 3) ? 1'b1 : logic'($urandom_range(0, 2) != 0);
               else
                  rdy = logic'($urandom_range(0, 1));
               applyStimulus(1'b0, o, rdy);
               @(negedge clock);
               checkOutput($sformatf("instr%0d_op%b_st%0d", n, o, st), st, expOut(st, o, rdy));
               cyc++;
               if (InstrDone === 1'b1 && doneAt < 0) doneAt = cyc;
               nextCycle();
               if ((st == 0 || st == 3 || st == 5) && !rdy) begin
                  waits++;
                  nWait++;
               end
            end while ((st == 0 || st == 3 || st == 5) && !rdy);
         end
         checks++;
         assert (doneAt === BASE_CYC[kind] + waits) else begin
            errors++;
            $error("[TB] FAIL cycles_op%b observed=%0d expected=%0d", o, doneAt, BASE_CYC[kind] + waits);
         end
      end

      // Store stalled in MEMWRITE, then reset lands while the write is still pending.
      o = 7'b0100011;
      applyStimulus(1'b0, o, 1'b1);
      @(negedge clock);
      checkOutput("sw_fetch", 0, expOut(0, o, 1'b1));
      nextCycle();
      nextCycle();
      nextCycle();
      applyStimulus(1'b0, o, 1'b0);
      @(negedge clock);
      checkOutput("sw_memwrite_wait", 5, expOut(5, o, 1'b0));
      nextCycle();
      applyStimulus(1'b1, o, 1'b0);
      @(negedge clock);
      checkOutput("reset_in_memwrite", 5, RESET_VEC);
      nextCycle();
      applyStimulus(1'b0, o, 1'b0);
      @(negedge clock);
      checkOutput("after_reset", 0, expOut(0, o, 1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
